// File: rtl/decode_stage_pkg.sv
// Shared opcode constants, decoder control word and stage state encoding
// for the N-lane decode stage.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    CL_ILLEGAL = 4'd0,
    CL_LUI     = 4'd1,
    CL_AUIPC   = 4'd2,
    CL_JAL     = 4'd3,
    CL_JALR    = 4'd4,
    CL_BRANCH  = 4'd5,
    CL_LOAD    = 4'd6,
    CL_STORE   = 4'd7,
    CL_OPIMM   = 4'd8,
    CL_OP      = 4'd9
  } op_class_e;

  // Per-lane control word handed to issue.
  typedef struct packed {
    op_class_e  cls;
    logic [2:0] funct3;
    logic [4:0] rd;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic {
    DS_IDLE = 1'b0,
    DS_HOLD = 1'b1
  } ds_state_e;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and issue-side handshake bundle of the decode stage.
interface decode_stage_if
  import decode_stage_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32
);

  logic                    flush_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [WIDTH*XLEN-1:0]   inst_i;
  logic [WIDTH-1:0]        slot_valid_i;
  logic [XLEN-1:0]         pc_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [WIDTH*XLEN-1:0]   inst_o;
  logic [WIDTH*CTRL_W-1:0] ctrl_o;
  logic [WIDTH*XLEN-1:0]   pc_o;
  logic [WIDTH-1:0]        slot_valid_o;
  logic                    split_o;

  modport slave (
    input  flush_i, in_valid_i, inst_i, slot_valid_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, inst_o, ctrl_o, pc_o, slot_valid_o, split_o
  );

  modport master (
    output flush_i, in_valid_i, inst_i, slot_valid_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, inst_o, ctrl_o, pc_o, slot_valid_o, split_o
  );

endinterface

// File: rtl/decode_stage_reg_use.sv
// Per-lane register-use extraction: which architectural registers an
// instruction writes and reads, used by the intra-bundle hazard check.
module reg_use
  import decode_stage_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [4:0] rd_field_i,
  input  logic [4:0] rs1_field_i,
  input  logic [4:0] rs2_field_i,
  output logic [4:0] rd_o,
  output logic [4:0] rs1_o,
  output logic [4:0] rs2_o,
  output logic       wr_en_o,
  output logic       rs1_en_o,
  output logic       rs2_en_o
);

  assign rd_o  = rd_field_i;
  assign rs1_o = rs1_field_i;
  assign rs2_o = rs2_field_i;

  always_comb begin
    wr_en_o  = 1'b0;
    rs1_en_o = 1'b0;
    rs2_en_o = 1'b0;
    case (opcode_i)
      OPC_LUI, OPC_AUIPC, OPC_JAL: wr_en_o = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        wr_en_o  = 1'b1;
        rs1_en_o = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        rs1_en_o = 1'b1;
        rs2_en_o = 1'b1;
      end
      OPC_OP: begin
        wr_en_o  = 1'b1;
        rs1_en_o = 1'b1;
        rs2_en_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decoder.sv
// Single-lane instruction decoder producing the control word for issue.
module decoder
  import decode_stage_pkg::*;
(
  input  logic [14:0] inst_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o.cls    = CL_ILLEGAL;
    ctrl_o.funct3 = inst_i[14:12];
    ctrl_o.rd     = inst_i[11:7];
    case (inst_i[6:0])
      OPC_LUI:    ctrl_o.cls = CL_LUI;
      OPC_AUIPC:  ctrl_o.cls = CL_AUIPC;
      OPC_JAL:    ctrl_o.cls = CL_JAL;
      OPC_JALR:   ctrl_o.cls = CL_JALR;
      OPC_BRANCH: ctrl_o.cls = CL_BRANCH;
      OPC_LOAD:   ctrl_o.cls = CL_LOAD;
      OPC_STORE:  ctrl_o.cls = CL_STORE;
      OPC_OPIMM:  ctrl_o.cls = CL_OPIMM;
      OPC_OP:     ctrl_o.cls = CL_OP;
      default:    ctrl_o.cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered N-lane decode stage: a fetch bundle is cut at the first lane that
// reads a register written by an earlier lane, and the rest issues later.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int XLEN  = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  decode_stage_if.slave bus
);

  ds_state_e               state_q;
  logic [WIDTH-1:0]        pend_q;
  logic [WIDTH*XLEN-1:0]   held_inst_q;
  logic [XLEN-1:0]         held_pc_q;
  logic                    out_valid_q;
  logic                    split_q;
  logic [WIDTH-1:0]        slot_valid_q;
  logic [WIDTH*XLEN-1:0]   inst_q, inst_d;
  logic [WIDTH*XLEN-1:0]   pc_q, pc_d;
  logic [WIDTH*CTRL_W-1:0] ctrl_q, ctrl_d;

  logic             advance, in_ready, accept, load_out;
  logic [XLEN-1:0]  work_pc;
  logic [WIDTH-1:0] work_mask, lane_conf, below_cut, grp, rest;
  logic [WIDTH-1:0] wr_en, rs1_en, rs2_en;
  logic [4:0]       rd  [WIDTH];
  logic [4:0]       rs1 [WIDTH];
  logic [4:0]       rs2 [WIDTH];

  assign advance  = !out_valid_q || bus.out_ready_i;
  assign in_ready = advance && (state_q == DS_IDLE) && !bus.flush_i;
  assign accept   = in_ready && bus.in_valid_i;

  // Working set: the held remainder while splitting, else the accepted bundle.
  assign inst_d    = (state_q == DS_HOLD) ? held_inst_q : bus.inst_i;
  assign work_pc   = (state_q == DS_HOLD) ? held_pc_q : bus.pc_i;
  assign work_mask = (state_q == DS_HOLD) ? pend_q
                   : (accept ? bus.slot_valid_i : '0);

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    ctrl_t ctrl_lane;
    logic  hit;

    reg_use u_reg_use (
      .opcode_i    (inst_d[k*XLEN +: 7]),
      .rd_field_i  (inst_d[k*XLEN+7 +: 5]),
      .rs1_field_i (inst_d[k*XLEN+15 +: 5]),
      .rs2_field_i (inst_d[k*XLEN+20 +: 5]),
      .rd_o        (rd[k]),
      .rs1_o       (rs1[k]),
      .rs2_o       (rs2[k]),
      .wr_en_o     (wr_en[k]),
      .rs1_en_o    (rs1_en[k]),
      .rs2_en_o    (rs2_en[k])
    );

    decoder u_decoder (
      .inst_i (inst_d[k*XLEN +: 15]),
      .ctrl_o (ctrl_lane)
    );

    assign ctrl_d[k*CTRL_W +: CTRL_W] = ctrl_lane;
    assign pc_d[k*XLEN +: XLEN]       = work_pc + XLEN'(4 * k);

    // Row k of the hazard matrix: any earlier working lane writing a source of lane k.
    always_comb begin
      hit = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (work_mask[j] && wr_en[j] && (rd[j] != 5'd0) &&
            ((rs1_en[k] && (rs1[k] == rd[j])) || (rs2_en[k] && (rs2[k] == rd[j]))))
          hit = 1'b1;
      end
    end

    assign lane_conf[k] = work_mask[k] && hit;
    assign below_cut[k] = ~|lane_conf[k:0];
  end

  assign grp      = work_mask & below_cut;
  assign rest     = work_mask & ~below_cut;
  assign load_out = advance && (|grp) && !bus.flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      state_q      <= DS_IDLE;
      pend_q       <= '0;
      out_valid_q  <= 1'b0;
      split_q      <= 1'b0;
      slot_valid_q <= '0;
    end else if (advance) begin
      out_valid_q <= |grp;
      if (|grp) begin
        slot_valid_q <= grp;
        split_q      <= |rest;
      end
      case (state_q)
        DS_IDLE: begin
          if (accept) begin
            pend_q <= rest;
            if (|rest) state_q <= DS_HOLD;
          end
        end
        DS_HOLD: begin
          pend_q <= rest;
          if (rest == '0) state_q <= DS_IDLE;
        end
        default: state_q <= DS_IDLE;
      endcase
    end
  end

  // Output register stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_q <= '0;
      ctrl_q <= '0;
      pc_q   <= '0;
    end else if (load_out) begin
      inst_q <= inst_d;
      ctrl_q <= ctrl_d;
      pc_q   <= pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      held_inst_q <= bus.inst_i;
      held_pc_q   <= bus.pc_i;
    end
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.inst_o       = inst_q;
  assign bus.ctrl_o       = ctrl_q;
  assign bus.pc_o         = pc_q;
  assign bus.slot_valid_o = slot_valid_q;
  assign bus.split_o      = split_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: WIDTH=2 and WIDTH=4 instances checked every cycle
// against a bundle-level reference model, plus directed scenarios.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        s_rst;
  logic        s_valid [2];
  logic        s_flush [2];
  logic        s_ordy  [2];
  logic [3:0]  s_sv    [2];
  logic [31:0] s_inst  [2][4];
  logic [31:0] s_pc    [2];

  logic                  o_ov    [2];
  logic                  o_rdy   [2];
  logic                  o_split [2];
  logic [3:0]            o_sv    [2];
  logic [127:0]          o_inst  [2];
  logic [127:0]          o_pc    [2];
  logic [4*CTRL_W-1:0]   o_ctrl  [2];

  decode_stage_if #(.WIDTH(2), .XLEN(32)) bus2 ();
  decode_stage_if #(.WIDTH(4), .XLEN(32)) bus4 ();

  decode_stage #(.WIDTH(2), .XLEN(32)) u_dut2 (.clk_i(clk), .rst_i(s_rst), .bus(bus2));
  decode_stage #(.WIDTH(4), .XLEN(32)) u_dut4 (.clk_i(clk), .rst_i(s_rst), .bus(bus4));

  assign bus2.flush_i      = s_flush[0];
  assign bus2.in_valid_i   = s_valid[0];
  assign bus2.out_ready_i  = s_ordy[0];
  assign bus2.slot_valid_i = s_sv[0][1:0];
  assign bus2.pc_i         = s_pc[0];
  assign bus2.inst_i       = {s_inst[0][1], s_inst[0][0]};
  assign bus4.flush_i      = s_flush[1];
  assign bus4.in_valid_i   = s_valid[1];
  assign bus4.out_ready_i  = s_ordy[1];
  assign bus4.slot_valid_i = s_sv[1];
  assign bus4.pc_i         = s_pc[1];
  assign bus4.inst_i       = {s_inst[1][3], s_inst[1][2], s_inst[1][1], s_inst[1][0]};

  assign o_ov[0]    = bus2.out_valid_o;
  assign o_rdy[0]   = bus2.in_ready_o;
  assign o_split[0] = bus2.split_o;
  assign o_sv[0]    = {2'b00, bus2.slot_valid_o};
  assign o_inst[0]  = {64'd0, bus2.inst_o};
  assign o_pc[0]    = {64'd0, bus2.pc_o};
  assign o_ctrl[0]  = {{(2*CTRL_W){1'b0}}, bus2.ctrl_o};
  assign o_ov[1]    = bus4.out_valid_o;
  assign o_rdy[1]   = bus4.in_ready_o;
  assign o_split[1] = bus4.split_o;
  assign o_sv[1]    = bus4.slot_valid_o;
  assign o_inst[1]  = bus4.inst_o;
  assign o_pc[1]    = bus4.pc_o;
  assign o_ctrl[1]  = bus4.ctrl_o;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit writes_rd(logic [31:0] i);
    case (i[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit reads_rs1(logic [31:0] i);
    case (i[6:0])
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit reads_rs2(logic [31:0] i);
    case (i[6:0])
      OPC_BRANCH, OPC_STORE, OPC_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // True when the later instruction b reads a nonzero register written by a.
  function automatic bit raw(logic [31:0] a, logic [31:0] b);
    if (!writes_rd(a) || a[11:7] == 5'd0) return 1'b0;
    return (reads_rs1(b) && b[19:15] == a[11:7]) || (reads_rs2(b) && b[24:20] == a[11:7]);
  endfunction

  function automatic logic [CTRL_W-1:0] exp_ctrl(logic [31:0] i);
    ctrl_t c;
    case (i[6:0])
      OPC_LUI:    c.cls = CL_LUI;
      OPC_AUIPC:  c.cls = CL_AUIPC;
      OPC_JAL:    c.cls = CL_JAL;
      OPC_JALR:   c.cls = CL_JALR;
      OPC_BRANCH: c.cls = CL_BRANCH;
      OPC_LOAD:   c.cls = CL_LOAD;
      OPC_STORE:  c.cls = CL_STORE;
      OPC_OPIMM:  c.cls = CL_OPIMM;
      OPC_OP:     c.cls = CL_OP;
      default:    c.cls = CL_ILLEGAL;
    endcase
    c.funct3 = i[14:12];
    c.rd     = i[11:7];
    return c;
  endfunction

  logic        m_ov    [2] = '{1'b0, 1'b0};
  logic        m_hold  [2] = '{1'b0, 1'b0};
  logic        m_split [2] = '{1'b0, 1'b0};
  logic [3:0]  m_pend  [2] = '{4'd0, 4'd0};
  logic [3:0]  m_osv   [2] = '{4'd0, 4'd0};
  logic [31:0] m_hinst [2][4];
  logic [31:0] m_oinst [2][4];
  logic [31:0] m_hpc   [2];
  logic [31:0] m_opc   [2];

  task automatic model_step(input int d);
    int          w, c;
    bit          adv;
    logic [31:0] wi [4];
    logic [31:0] wpc;
    logic [3:0]  wm, grp, rest;
    w   = (d == 0) ? 2 : 4;
    adv = !m_ov[d] || s_ordy[d];
    if (s_rst || s_flush[d]) begin
      m_ov[d] = 1'b0; m_hold[d] = 1'b0; m_pend[d] = '0; m_split[d] = 1'b0;
      return;
    end
    if (!adv) return;
    wm  = '0;
    wpc = s_pc[d];
    for (int k = 0; k < 4; k++) wi[k] = s_inst[d][k];
    if (m_hold[d]) begin
      for (int k = 0; k < 4; k++) wi[k] = m_hinst[d][k];
      wpc = m_hpc[d];
      wm  = m_pend[d];
    end else if (s_valid[d]) begin
      wm = s_sv[d] & 4'((1 << w) - 1);
    end
    c = w;
    for (int k = w - 1; k >= 0; k--)
      for (int j = 0; j < k; j++)
        if (wm[j] && wm[k] && raw(wi[j], wi[k])) c = k;
    grp  = wm & 4'((1 << c) - 1);
    rest = wm & ~grp;
    if (grp != 0) begin
      m_ov[d] = 1'b1; m_osv[d] = grp; m_opc[d] = wpc; m_split[d] = (rest != 0);
      for (int k = 0; k < 4; k++) m_oinst[d][k] = wi[k];
    end else begin
      m_ov[d] = 1'b0;
    end
    if (m_hold[d] || s_valid[d]) begin
      m_pend[d] = rest; m_hpc[d] = wpc; m_hold[d] = (rest != 0);
      for (int k = 0; k < 4; k++) m_hinst[d][k] = wi[k];
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cmp_model(input int d);
    int w;
    w = (d == 0) ? 2 : 4;
    check_eq($sformatf("w%0d out_valid", w), o_ov[d], m_ov[d]);
    check_eq($sformatf("w%0d in_ready", w), o_rdy[d],
             (!m_ov[d] || s_ordy[d]) && !m_hold[d] && !s_flush[d]);
    if (m_ov[d]) begin
      check_eq($sformatf("w%0d split", w), o_split[d], m_split[d]);
      check_eq($sformatf("w%0d slot_valid", w), o_sv[d], m_osv[d]);
      for (int k = 0; k < w; k++) begin
        if (m_osv[d][k]) begin
          check_eq($sformatf("w%0d inst lane%0d", w, k), o_inst[d][k*32 +: 32], m_oinst[d][k]);
          check_eq($sformatf("w%0d pc lane%0d", w, k), o_pc[d][k*32 +: 32], m_opc[d] + 32'(4 * k));
          check_eq($sformatf("w%0d ctrl lane%0d", w, k), o_ctrl[d][k*CTRL_W +: CTRL_W],
                   exp_ctrl(m_oinst[d][k]));
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cmp_model(0);
    cmp_model(1);
  endtask

  task automatic drive2(input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] pc, input logic [3:0] sv);
    s_valid[0] = 1'b1; s_inst[0][0] = i0; s_inst[0][1] = i1; s_pc[0] = pc; s_sv[0] = sv;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  op;
    logic [31:0] i;
    case ($urandom_range(0, 9))
      0: op = OPC_LUI;    1: op = OPC_AUIPC; 2: op = OPC_JAL;   3: op = OPC_JALR;
      4: op = OPC_BRANCH; 5: op = OPC_LOAD;  6: op = OPC_STORE; 7: op = OPC_OPIMM;
      8: op = OPC_OP;     default: op = 7'h7f;
    endcase
    i        = $urandom();
    i[6:0]   = op;
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  initial begin
    s_rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0; s_flush[d] = 1'b0; s_ordy[d] = 1'b1; s_sv[d] = '0; s_pc[d] = '0;
      for (int k = 0; k < 4; k++) s_inst[d][k] = '0;
    end
    repeat (2) cyc();
    for (int d = 0; d < 2; d++) begin
      check_eq("reset out_valid", o_ov[d], 1'b0);
      check_eq("reset slot_valid", o_sv[d], 4'd0);
      check_eq("reset split", o_split[d], 1'b0);
      check_eq("reset pc_o", o_pc[d], 128'd0);
      check_eq("reset in_ready", o_rdy[d], 1'b1);
    end
    s_rst = 1'b0;
    cyc();

    // independent pair
    drive2(32'h00500093, 32'h00600113, 32'h100, 4'b0011);
    cyc();
    s_valid[0] = 1'b0;
    check_eq("pair slot_valid", o_sv[0], 4'b0011);
    check_eq("pair pc_o", o_pc[0][63:0], {32'h104, 32'h100});
    check_eq("pair split", o_split[0], 1'b0);

    // RAW split
    drive2(32'h00500093, 32'h00108113, 32'h200, 4'b0011);
    cyc();
    s_valid[0] = 1'b0;
    check_eq("raw c1 slot_valid", o_sv[0], 4'b0001);
    check_eq("raw c1 split", o_split[0], 1'b1);
    check_eq("raw c1 in_ready", o_rdy[0], 1'b0);
    cyc();
    check_eq("raw c2 slot_valid", o_sv[0], 4'b0010);
    check_eq("raw c2 lane1 pc", o_pc[0][63:32], 32'h204);
    check_eq("raw c2 split", o_split[0], 1'b0);

    // x0 writer does not create a hazard
    drive2(32'h00500013, 32'h00100093, 32'h300, 4'b0011);
    cyc();
    s_valid[0] = 1'b0;
    check_eq("x0 slot_valid", o_sv[0], 4'b0011);
    check_eq("x0 split", o_split[0], 1'b0);

    // back-pressure
    drive2(32'h00500093, 32'h00600113, 32'h400, 4'b0011);
    cyc();
    s_ordy[0] = 1'b0;
    drive2(32'h00700193, 32'h00800213, 32'h500, 4'b0011);
    for (int n = 0; n < 3; n++) begin
      cyc();
      check_eq("stall pc held", o_pc[0][31:0], 32'h400);
      check_eq("stall in_ready", o_rdy[0], 1'b0);
      check_eq("stall out_valid", o_ov[0], 1'b1);
    end
    s_ordy[0] = 1'b1;
    cyc();
    s_valid[0] = 1'b0;
    check_eq("release next pc", o_pc[0][31:0], 32'h500);

    // flush in the middle of a split
    drive2(32'h00500093, 32'h00108113, 32'h600, 4'b0011);
    cyc();
    s_valid[0] = 1'b0;
    s_flush[0] = 1'b1;
    cyc();
    check_eq("flush out_valid", o_ov[0], 1'b0);
    check_eq("flush split", o_split[0], 1'b0);
    s_flush[0] = 1'b0;
    #1;
    check_eq("flush in_ready", o_rdy[0], 1'b1);
    for (int n = 0; n < 3; n++) begin
      cyc();
      check_eq("flush lane1 dropped", o_ov[0], 1'b0);
    end

    // empty bundle is consumed silently
    drive2(32'h00500093, 32'h00600113, 32'h700, 4'b0000);
    cyc();
    s_valid[0] = 1'b0;
    check_eq("empty out_valid", o_ov[0], 1'b0);
    check_eq("empty in_ready", o_rdy[0], 1'b1);

    // WIDTH=4 dependency chain
    s_valid[1] = 1'b1; s_sv[1] = 4'hf; s_pc[1] = 32'h800;
    s_inst[1][0] = 32'h00100093; s_inst[1][1] = 32'h00108113;
    s_inst[1][2] = 32'h00300193; s_inst[1][3] = 32'h00118213;
    cyc();
    s_valid[1] = 1'b0;
    check_eq("chain g1 slot_valid", o_sv[1], 4'b0001);
    check_eq("chain g1 split", o_split[1], 1'b1);
    check_eq("chain g1 in_ready", o_rdy[1], 1'b0);
    cyc();
    check_eq("chain g2 slot_valid", o_sv[1], 4'b0110);
    check_eq("chain g2 split", o_split[1], 1'b1);
    check_eq("chain g2 lane2 pc", o_pc[1][95:64], 32'h808);
    cyc();
    check_eq("chain g3 slot_valid", o_sv[1], 4'b1000);
    check_eq("chain g3 split", o_split[1], 1'b0);
    check_eq("chain g3 lane3 pc", o_pc[1][127:96], 32'h80c);
    cyc();
    check_eq("chain done", o_ov[1], 1'b0);

    // randomized traffic on both widths
    for (int n = 0; n < 3000; n++) begin
      cyc();
      s_rst = ($urandom_range(0, 399) == 0);
      for (int d = 0; d < 2; d++) begin
        s_valid[d] = ($urandom_range(0, 3) != 0);
        s_ordy[d]  = ($urandom_range(0, 3) != 0);
        s_flush[d] = ($urandom_range(0, 31) == 0);
        s_sv[d]    = 4'($urandom_range(0, 15));
        s_pc[d]    = $urandom() & 32'hffff_fffc;
        for (int k = 0; k < 4; k++) s_inst[d][k] = rand_inst();
      end
    end
    s_rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0; s_flush[d] = 1'b0; s_ordy[d] = 1'b1;
    end
    repeat (6) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
